// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - time-shares one external sevenseg decoder across NDIGITS hex digits
module hex_display_ctrl #(
  parameter int NDIGITS     = 6,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [4*NDIGITS-1:0] wr_data,
  input  logic                 display_on,
  output logic                 wr_ack,
  output logic                 busy,
  output logic [3:0]           dec_in,
  output logic                 dec_ctrl,
  input  logic [6:0]           dec_out,
  output logic [7*NDIGITS-1:0] hex_out
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE} state_t;

  state_t               state, state_next;
  logic [4*NDIGITS-1:0] value, snap, snap_next, sel_snap, shifted;
  logic [IW-1:0]        idx, idx_next;
  logic [CW-1:0]        rcnt;
  logic                 pending, tc, req, start, load_dec, blank;

  always_comb begin
    tc         = (rcnt == LAST_CNT);
    req        = wr_en | tc | pending;
    start      = 1'b0;
    load_dec   = 1'b0;
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE:    if (req) start = 1'b1;
      SELECT:  state_next = CAPTURE;
      CAPTURE: begin
        if (idx == LAST_IDX) begin
          if (req) start = 1'b1;
          else     state_next = IDLE;
        end else begin
          state_next = SELECT;
          idx_next   = idx + 1'b1;
          load_dec   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      state_next = SELECT;
      idx_next   = '0;
      load_dec   = 1'b1;
    end
    // A write in the same cycle as a sweep start must be the data that sweep shows
    snap_next = wr_en ? wr_data : value;
    sel_snap  = start ? snap_next : snap;
    shifted   = sel_snap >> {idx_next, 2'b00};
    blank     = BLANK_LZ && (idx_next != '0) && (shifted == '0);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      value    <= '0;
      snap     <= '0;
      idx      <= '0;
      rcnt     <= '0;
      pending  <= 1'b0;
      wr_ack   <= 1'b0;
      dec_in   <= 4'h0;
      dec_ctrl <= 1'b0;
      hex_out  <= '1;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      wr_ack <= wr_en;
      rcnt   <= tc ? '0 : rcnt + 1'b1;
      if (wr_en) value <= wr_data;
      if (start) snap <= snap_next;
      if (start)                              pending <= 1'b0;
      else if ((state != IDLE) && (wr_en || tc)) pending <= 1'b1;
      if (load_dec) begin
        dec_in   <= shifted[3:0];
        dec_ctrl <= display_on & ~blank;
      end
      // Decoder result for the selected digit is sampled on the edge that enters CAPTURE
      if (state == SELECT) begin
        for (int k = 0; k < NDIGITS; k++) begin
          if (idx == IW'(k)) hex_out[7*k +: 7] <= dec_ctrl ? dec_out : 7'h7F;
        end
      end
    end
  end
endmodule
